// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in, parallel-out deserializer.
// Optional even parity is enabled by defining SIPO_PARITY_EN.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

endpackage

// File: rtl/sipo_out_reg.sv
// Output word register with valid/ready handshake and overrun detection.
// Carries the parity error flag alongside the word when SIPO_PARITY_EN is defined.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
`ifdef SIPO_PARITY_EN
    input  logic             word_perr,
    output logic             par_err,
`endif
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    logic accept;

    // A slot is free if empty or being drained on this same edge.
    assign accept = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (accept) begin
                    data  <= word;
                    valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    par_err <= word_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Framed MSB-first serial-to-parallel deserializer with valid/ready output.
// Define SIPO_PARITY_EN to add a trailing even-parity bit and Parity_Err.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Serial_In,
    input  logic             Serial_Valid,
    input  logic             Frame_Start,
    output logic [WIDTH-1:0] Parallel_Out,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Overrun,
`ifdef SIPO_PARITY_EN
    output logic             Parity_Err,
`endif
    output logic             Frame_Abort
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Without parity the final bit goes straight to the output register,
    // so only WIDTH-1 bits ever need to be held.
`ifdef SIPO_PARITY_EN
    localparam int SREG_W = WIDTH;
`else
    localparam int SREG_W = WIDTH - 1;
`endif

    sipo_state_t       state;
    logic [CW-1:0]     count;
    logic [SREG_W-1:0] sreg;
    logic [WIDTH-1:0]  next_word;
    logic [WIDTH-1:0]  done_word;
    logic              restart;
    logic              word_done;

    assign next_word = {sreg[WIDTH-2:0], Serial_In};
    assign restart   = Serial_Valid & Frame_Start;

`ifdef SIPO_PARITY_EN
    logic done_perr;

    assign word_done = Serial_Valid & ~Frame_Start & (state == PARITY);
    assign done_word = sreg;
    assign done_perr = (^sreg) ^ Serial_In;
`else
    assign word_done = Serial_Valid & ~Frame_Start
                     & (state == SHIFT) & (count == LAST);
    assign done_word = next_word;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            count       <= '0;
            sreg        <= '0;
            Frame_Abort <= 1'b0;
        end else begin
            Frame_Abort <= restart && (state != IDLE);
            if (restart) begin
                sreg  <= SREG_W'(Serial_In);
                count <= CW'(1);
                state <= SHIFT;
            end else if (Serial_Valid) begin
                unique case (state)
                    IDLE: begin
                    end
                    SHIFT: begin
                        sreg <= next_word[SREG_W-1:0];
`ifdef SIPO_PARITY_EN
                        count <= count + CW'(1);
                        if (count == LAST) state <= PARITY;
`else
                        if (count == LAST) begin
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            count <= count + CW'(1);
                        end
`endif
                    end
                    default: begin
                        count <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    sipo_out_reg #(
        .WIDTH     (WIDTH)
    ) u_out (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (word_done),
        .word      (done_word),
`ifdef SIPO_PARITY_EN
        .word_perr (done_perr),
        .par_err   (Parity_Err),
`endif
        .ready     (Out_Ready),
        .data      (Parallel_Out),
        .valid     (Out_Valid),
        .overrun   (Overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: directed frames, monitor checks words.
// Build with SIPO_PARITY_EN defined to exercise the parity variant.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Serial_In = 1'b0;
    logic         Serial_Valid = 1'b0;
    logic         Frame_Start = 1'b0;
    logic         Out_Ready = 1'b0;
    logic [W-1:0] Parallel_Out;
    logic         Out_Valid;
    logic         Overrun;
    logic         Frame_Abort;
`ifdef SIPO_PARITY_EN
    logic         Parity_Err;
`endif

    logic [W:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int ov_seen = 0;
    int ab_seen = 0;
    int ov0, ab0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Serial_In    (Serial_In),
        .Serial_Valid (Serial_Valid),
        .Frame_Start  (Frame_Start),
        .Parallel_Out (Parallel_Out),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Overrun      (Overrun),
`ifdef SIPO_PARITY_EN
        .Parity_Err   (Parity_Err),
`endif
        .Frame_Abort  (Frame_Abort)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words whenever a handshake completes.
    logic [W:0] e;
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Overrun) ov_seen++;
            if (Frame_Abort) ab_seen++;
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             Parallel_Out);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 32'(Parallel_Out), 32'(e[W-1:0]));
`ifdef SIPO_PARITY_EN
                    chk("parity_err", 32'(Parity_Err), 32'(e[W]));
`endif
                end
            end
        end
    end

    task automatic send(input logic fs, input logic b);
        Serial_Valid = 1'b1;
        Frame_Start  = fs;
        Serial_In    = b;
        @(posedge Clk);
        #1;
        Serial_Valid = 1'b0;
        Frame_Start  = 1'b0;
        Serial_In    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) send(i == W - 1, d[i]);
`ifdef SIPO_PARITY_EN
        send(1'b0, ^d);
`endif
    endtask

    initial begin
        Out_Ready = 1'b1;
        idle(2);
        chk("rst_data", 32'(Parallel_Out), 32'h0);
        chk("rst_valid", 32'(Out_Valid), 32'h0);
        chk("rst_overrun", 32'(Overrun), 32'h0);
        chk("rst_abort", 32'(Frame_Abort), 32'h0);
        Rst_n = 1'b1;
        idle(1);

        // Basic frame, latency of one edge after last bit
        exp_q.push_back({1'b0, 4'b1011});
        send_word(4'b1011);
        chk("t1_valid", 32'(Out_Valid), 32'h1);
        chk("t1_data", 32'(Parallel_Out), 32'hB);
        chk("t1_overrun", 32'(Overrun), 32'h0);
        chk("t1_abort", 32'(Frame_Abort), 32'h0);
        idle(1);
        chk("t1_valid_clear", 32'(Out_Valid), 32'h0);

        // Serial_Valid gap mid-frame
        exp_q.push_back({1'b0, 4'b1011});
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        idle(3);
        chk("t2_hold", 32'(Out_Valid), 32'h0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
`ifdef SIPO_PARITY_EN
        send(1'b0, 1'b1);
`endif
        chk("t2_valid", 32'(Out_Valid), 32'h1);
        idle(1);

        // Back-to-back frames with consumer stalled
        Out_Ready = 1'b0;
        ov0 = ov_seen;
        exp_q.push_back({1'b0, 4'hA});
        send_word(4'hA);
        send_word(4'h5);
        idle(2);
        chk("t3_data", 32'(Parallel_Out), 32'hA);
        chk("t3_valid", 32'(Out_Valid), 32'h1);
        chk("t3_overrun", 32'(ov_seen - ov0), 32'h1);
        Out_Ready = 1'b1;
        idle(1);
        chk("t3_consumed", 32'(Out_Valid), 32'h0);

        // Frame_Start on bit 3 restarts the frame
        ab0 = ab_seen;
        exp_q.push_back({1'b0, 4'hC});
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        send(1'b0, 1'b0);
`endif
        chk("t4_data", 32'(Parallel_Out), 32'hC);
        idle(2);
        chk("t4_abort", 32'(ab_seen - ab0), 32'h1);

        // Async reset mid-frame with a pending word
        Out_Ready = 1'b0;
        send_word(4'h6);
        chk("t5_pending", 32'(Out_Valid), 32'h1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(Out_Valid), 32'h0);
        chk("t5_rst_data", 32'(Parallel_Out), 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < W + 1; i++) send(1'b0, 1'b1);
        idle(1);
        chk("t5_ignored", 32'(Out_Valid), 32'h0);

        exp_q.push_back({1'b0, 4'h9});
        send_word(4'h9);
        idle(2);

`ifdef SIPO_PARITY_EN
        exp_q.push_back({1'b0, 4'b1011});
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        idle(2);
        Out_Ready = 1'b0;
        exp_q.push_back({1'b1, 4'b1011});
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        chk("p_err_flag", 32'(Parity_Err), 32'h1);
        Out_Ready = 1'b1;
        idle(2);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
